s100_addr_pattern_gen: RTL

Parametrised S100 bus address-line exerciser for the T35 SBC. Runs a repeating sequence of bus cycles (T1/T2/T3), driving a programmable address pattern together with pSYNC, pSTVAL, pDBIN and n_pWR, so that every address line and status strobe can be checked on a logic analyser or bus-monitor card. It replaces the fixed 16-bit count-up address test with selectable width, four pattern modes, read/write cycle type, single-step and pass counting. Sits between the top level and the S100 address/status pad buffers.

---
 rtl/s100_test_pkg.sv | 16 +
 rtl/s100_addr_pattern_step.sv | 60 ++++++
 rtl/s100_addr_pattern_gen.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/s100_test_pkg.sv
// Shared encodings for the S100 address-line exerciser: pattern modes and bus-cycle states.
package s100_test_pkg;

    localparam logic [1:0] MODE_COUNT = 2'd0;
    localparam logic [1:0] MODE_WALK1 = 2'd1;
    localparam logic [1:0] MODE_WALK0 = 2'd2;
    localparam logic [1:0] MODE_FIXED = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } bus_state_t;

endpackage

// File: rtl/s100_addr_pattern_step.sv
// Combinational pattern stepper: given mode, walking index and current address, yields the
// next address/index, the pass-wrap flag and the first element of the selected pattern.
module s100_addr_pattern_step
    import s100_test_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int IDX_W  = 5
) (
    input  logic [1:0]        i_mode,
    input  logic [IDX_W-1:0]  i_index,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [ADDR_W-1:0] o_nextAddr,
    output logic [IDX_W-1:0]  o_nextIndex,
    output logic              o_wrap,
    output logic [ADDR_W-1:0] o_firstAddr
);

    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ADDR_W - 1);

    logic             w_lastIdx;
    logic [IDX_W-1:0] w_incIdx;

    always_comb begin
        w_lastIdx   = (i_index == LAST_IDX);
        w_incIdx    = w_lastIdx ? '0 : i_index + IDX_W'(1);
        o_nextAddr  = i_addr;
        o_nextIndex = i_index;
        o_wrap      = 1'b0;
        o_firstAddr = '0;
        case (i_mode)
            MODE_COUNT: begin
                o_nextAddr  = i_addr + ONE;
                o_nextIndex = '0;
                o_wrap      = &i_addr;
                o_firstAddr = '0;
            end
            MODE_WALK1: begin
                o_nextAddr  = ONE << w_incIdx;
                o_nextIndex = w_incIdx;
                o_wrap      = w_lastIdx;
                o_firstAddr = ONE;
            end
            MODE_WALK0: begin
                o_nextAddr  = ~(ONE << w_incIdx);
                o_nextIndex = w_incIdx;
                o_wrap      = w_lastIdx;
                o_firstAddr = ~ONE;
            end
            default: begin
                // Fixed mode re-captures its address on T1 entry; every cycle is a full pass.
                o_nextAddr  = i_addr;
                o_nextIndex = i_index;
                o_wrap      = 1'b1;
                o_firstAddr = i_addr;
            end
        endcase
    end

endmodule

// File: rtl/s100_addr_pattern_gen.sv
// S100 address-line exerciser: runs T1/T2/T3 bus cycles driving a programmable address pattern
// with pSYNC/pSTVAL/pDBIN/n_pWR strobes; all outputs registered.
module s100_addr_pattern_gen
    import s100_test_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int STATE_TICKS = 2,
    parameter int PASS_W      = 8
) (
    input  logic              clockIn,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic [1:0]        mode,
    input  logic              wr_cycle,
    input  logic [ADDR_W-1:0] fixed_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              pSYNC,
    output logic              pSTVAL,
    output logic              pDBIN,
    output logic              n_pWR,
    output logic              add_oe,
    output logic              busy,
    output logic              cycle_done,
    output logic [PASS_W-1:0] pass_count
);

    localparam int TICK_W = (STATE_TICKS > 1) ? $clog2(STATE_TICKS) : 1;
    localparam int IDX_W  = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(STATE_TICKS - 1);

    bus_state_t        r_state;
    bus_state_t        w_nextState;
    logic [TICK_W-1:0] r_tick;
    logic [TICK_W-1:0] w_nextTick;
    logic [ADDR_W-1:0] r_addr;
    logic [IDX_W-1:0]  r_index;
    logic [1:0]        r_mode;
    logic              r_wr;
    logic [PASS_W-1:0] r_pass;
    logic              r_pSYNC;
    logic              r_pSTVAL;
    logic              r_pDBIN;
    logic              r_nPWR;
    logic              r_addOe;
    logic              r_busy;
    logic              r_cycleDone;

    logic              w_start;
    logic              w_tickLast;
    logic              w_t3Expire;
    logic              w_wrNext;
    logic              w_dataPhase;
    logic [1:0]        w_stepMode;
    logic [ADDR_W-1:0] w_stepAddr;
    logic [IDX_W-1:0]  w_stepIndex;
    logic              w_stepWrap;
    logic [ADDR_W-1:0] w_firstAddr;

    // In IDLE the stepper is asked for the first element of the incoming mode; in T3 it advances the latched mode.
    assign w_stepMode = (r_state == IDLE) ? mode : r_mode;

    s100_addr_pattern_step #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_step (
        .i_mode      (w_stepMode),
        .i_index     (r_index),
        .i_addr      (r_addr),
        .o_nextAddr  (w_stepAddr),
        .o_nextIndex (w_stepIndex),
        .o_wrap      (w_stepWrap),
        .o_firstAddr (w_firstAddr)
    );

    always_comb begin
        w_start     = run || step;
        w_tickLast  = (r_tick == LAST_TICK);
        w_t3Expire  = (r_state == T3) && w_tickLast;
        w_nextState = r_state;
        w_nextTick  = r_tick;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_nextState = T1;
                    w_nextTick  = '0;
                end
            end
            T1: begin
                if (w_tickLast) begin
                    w_nextState = T2;
                    w_nextTick  = '0;
                end else begin
                    w_nextTick = r_tick + TICK_W'(1);
                end
            end
            T2: begin
                if (w_tickLast) begin
                    w_nextState = T3;
                    w_nextTick  = '0;
                end else begin
                    w_nextTick = r_tick + TICK_W'(1);
                end
            end
            T3: begin
                if (w_tickLast) begin
                    w_nextState = run ? T1 : IDLE;
                    w_nextTick  = '0;
                end else begin
                    w_nextTick = r_tick + TICK_W'(1);
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextTick  = '0;
            end
        endcase
        w_wrNext    = (r_state == IDLE) ? wr_cycle : r_wr;
        w_dataPhase = (w_nextState == T2) || (w_nextState == T3);
    end

    always_ff @(posedge clockIn or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_tick      <= '0;
            r_addr      <= '0;
            r_index     <= '0;
            r_mode      <= MODE_COUNT;
            r_wr        <= 1'b0;
            r_pass      <= '0;
            r_pSYNC     <= 1'b0;
            r_pSTVAL    <= 1'b0;
            r_pDBIN     <= 1'b0;
            r_nPWR      <= 1'b1;
            r_addOe     <= 1'b0;
            r_busy      <= 1'b0;
            r_cycleDone <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_tick      <= w_nextTick;
            r_cycleDone <= w_t3Expire;
            if ((r_state == IDLE) && w_start) begin
                r_mode <= mode;
                r_wr   <= wr_cycle;
                if (mode != r_mode) begin
                    r_index <= '0;
                end
                if (mode == MODE_FIXED) begin
                    r_addr <= fixed_addr;
                end else if (mode != r_mode) begin
                    r_addr <= w_firstAddr;
                end
            end else if (w_t3Expire) begin
                if (r_mode == MODE_FIXED) begin
                    if (run) begin
                        r_addr <= fixed_addr;
                    end
                end else begin
                    r_addr  <= w_stepAddr;
                    r_index <= w_stepIndex;
                end
                if (w_stepWrap) begin
                    r_pass <= r_pass + PASS_W'(1);
                end
            end
            // Strobes are registered from the next state so they line up exactly with the bus phase.
            r_pSYNC  <= (w_nextState == T1);
            r_pSTVAL <= (w_nextState == T2);
            r_pDBIN  <= w_dataPhase && !w_wrNext;
            r_nPWR   <= !(w_dataPhase && w_wrNext);
            r_addOe  <= (w_nextState != IDLE);
            r_busy   <= (w_nextState != IDLE);
        end
    end

    assign addr       = r_addr;
    assign pSYNC      = r_pSYNC;
    assign pSTVAL     = r_pSTVAL;
    assign pDBIN      = r_pDBIN;
    assign n_pWR      = r_nPWR;
    assign add_oe     = r_addOe;
    assign busy       = r_busy;
    assign cycle_done = r_cycleDone;
    assign pass_count = r_pass;

endmodule
